mem_stream_rr_arbiter: RTL and testbench
========================================

// Module: mem_stream_rr_arbiter
// PURPOSE
//  Shares one req/gnt/rvalid memory port (e.g. a detailed-mem or zero-mem sink) among NumReq
//  requesters. Round-robin arbitration with a per-cycle lock until grant; response routing via an
//  in-order FIFO of granted requester indices, bounded by MaxOutstanding.
//  Sits between several memory-stream masters and one memory bank or data sink.
// PARAMETERS
//  NumReq          2   number of requesters, >=1
//  AddrWidth      32   memory address width
//  DataWidth      64   data width, multiple of 8; strobe width DataWidth/8
//  MaxOutstanding  2   max granted-but-unanswered requests, >=1; set >= memory latency
// PORTS
//  clk_i        in   1                     clock
//  rst_ni       in   1                     asynchronous reset, active low
//  busy_o       out  1                     any request pending or any response outstanding
//  req_i        in   NumReq                per-requester request
//  gnt_o        out  NumReq                per-requester grant (one-hot or zero)
//  addr_i       in   NumReq*AddrWidth      per-requester address, packed, requester 0 at LSB
//  we_i         in   NumReq                per-requester write enable
//  wdata_i      in   NumReq*DataWidth      per-requester write data, packed
//  strb_i       in   NumReq*DataWidth/8    per-requester byte strobe, packed
//  rvalid_o     out  NumReq                per-requester response valid (one-hot or zero)
//  rdata_o      out  DataWidth             response data, broadcast to all requesters
//  mem_req_o    out  1                     memory request
//  mem_gnt_i    in   1                     memory grant
//  mem_addr_o   out  AddrWidth             selected address
//  mem_we_o     out  1                     selected write enable
//  mem_wdata_o  out  DataWidth             selected write data
//  mem_strb_o   out  DataWidth/8           selected strobe
//  mem_rvalid_i in   1                     memory response valid (one per granted request, reads and writes)
//  mem_rdata_i  in   DataWidth             memory response data
// BEHAVIOUR
//  - Reset: lock clear, RR pointer = NumReq-1 (requester 0 highest priority), FIFO empty,
//    count=0; all outputs 0 (gnt_o, rvalid_o, mem_req_o, busy_o = 0; mem_* payload = 0).
//  - Handshake fire = mem_req_o & mem_gnt_i. Requesters keep req_i and payload stable until their gnt_o.
//  - States: IDLE (no lock) / LOCKED (idx_q held). IDLE: pick first asserted req_i starting at
//    ptr+1 modulo NumReq. If FIFO not full, mem_req_o=1 and payload muxed from the pick.
//    No fire -> LOCKED with idx_q=pick. LOCKED: selection = idx_q regardless of other req_i;
//    mem_req_o stays 1 (payload stable); on fire -> IDLE.
//  - On fire: gnt_o[sel]=1 same cycle (combinational from mem_gnt_i); ptr<=sel; push sel into FIFO.
//  - FIFO full (count==MaxOutstanding): mem_req_o=0, no new grant, no lock entered; an existing
//    lock is kept. Pop in the same cycle does not unblock; request resumes next cycle (zero bubble
//    impossible when full; decided for determinism).
//  - Response: mem_rvalid_i with FIFO non-empty -> rvalid_o[head]=1 same cycle, pop; rdata_o =
//    mem_rdata_i (rdata_o=0 when mem_rvalid_i=0). Push and pop in one cycle: count unchanged.
//  - mem_rvalid_i with FIFO empty: protocol error; rvalid_o stays 0, response dropped; simulation
//    assertion fires.
//  - Index width max(1,$clog2(NumReq)); count width $clog2(MaxOutstanding+1); FIFO pointers wrap
//    modulo MaxOutstanding.
//  - NumReq=1: degenerates to pass-through with outstanding tracking; ptr unused.
//  - busy_o = |req_i | (count!=0) | lock.
//  - Reset mid-operation: all state cleared asynchronously; in-flight responses are not tracked;
//    memory must be reset together with this block.
//  - Assertions: gnt_o and rvalid_o one-hot-or-zero; payload stable while LOCKED; count<=MaxOutstanding.
// TESTING
//  1. req_i=2'b11 held, mem_gnt_i=1, 1-cycle rvalid: grants alternate 0,1,0,1; rvalid_o follows 1 cycle later.
//  2. req_i[0]=1 addr=0x100, mem_gnt_i=0 for 3 cycles, req_i[1] rises cycle 1: mem_addr_o stays 0x100
//     3 cycles, gnt_o=01 on grant cycle, then requester 1 granted next.
//  3. MaxOutstanding=2, mem_rvalid_i held 0, both requesting: exactly 2 grants, then mem_req_o=0;
//     one rvalid -> mem_req_o=1 next cycle, third grant.
//  4. Write req we=1 strb=0xFF wdata=0xDEAD from req 1: mem_we_o=1, mem_wdata_o=0xDEAD;
//     rvalid_o=2'b10 on response.
//  5. Spurious mem_rvalid_i with FIFO empty -> rvalid_o=0, assertion reported, count stays 0.
//  6. rst_ni low while 2 outstanding and LOCKED: all outputs 0 immediately; after release, req_i=2'b11
//     grants requester 0 first.

Source files
------------

// File: rtl/mem_stream_rr_arbiter.sv
// Round-robin arbiter that shares one req/gnt/rvalid memory port among NumReq requesters.
// A request that is not granted right away is locked until it is granted. The index of each
// granted requester goes into an in-order FIFO, and that FIFO routes the memory responses
// back to the right requester.
module mem_stream_rr_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  output logic                            busy_o,
  input  logic [NumReq-1:0]               req_i,
  output logic [NumReq-1:0]               gnt_o,
  input  logic [NumReq*AddrWidth-1:0]     addr_i,
  input  logic [NumReq-1:0]               we_i,
  input  logic [NumReq*DataWidth-1:0]     wdata_i,
  input  logic [NumReq*DataWidth/8-1:0]   strb_i,
  output logic [NumReq-1:0]               rvalid_o,
  output logic [DataWidth-1:0]            rdata_o,
  output logic                            mem_req_o,
  input  logic                            mem_gnt_i,
  output logic [AddrWidth-1:0]            mem_addr_o,
  output logic                            mem_we_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  output logic [DataWidth/8-1:0]          mem_strb_o,
  input  logic                            mem_rvalid_i,
  input  logic [DataWidth-1:0]            mem_rdata_i
);

  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned StrbW = DataWidth / 8;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic            state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [IdxW-1:0] fifo_d [MaxOutstanding];
  logic [PtrW-1:0] wr_q, wr_d;
  logic [PtrW-1:0] rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [IdxW-1:0] pick, cand, sel, head;
  logic            any_req, full, empty, req_int, fire, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Round-robin pick: the first asserted request, searching from ptr+1 and wrapping around
  always_comb begin
    pick    = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NumReq);
      if (!any_req && req_i[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  // Selection, handshake and response decode
  always_comb begin
    full    = (cnt_q == CntW'(MaxOutstanding));
    empty   = (cnt_q == '0);
    sel     = (state_q == ST_LOCKED) ? idx_q : pick;
    req_int = ((state_q == ST_LOCKED) || any_req) && !full;
    fire    = req_int && mem_gnt_i;
    pop     = mem_rvalid_i && !empty;
    head    = fifo_q[rd_q];
  end

  // Lock and round-robin pointer. A lock is only entered when a request is issued and not granted.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (fire) begin
      state_d = ST_IDLE;
      ptr_d   = sel;
    end else if (req_int && (state_q == ST_IDLE)) begin
      state_d = ST_LOCKED;
      idx_d   = sel;
    end
  end

  // FIFO of granted indices: push on fire, pop on response. Push and pop together leave the count unchanged.
  always_comb begin
    fifo_d = fifo_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (fire) begin
      fifo_d[wr_q] = sel;
      wr_d         = ptr_inc(wr_q);
    end
    if (pop) begin
      rd_d = ptr_inc(rd_q);
    end
    case ({fire, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ptr_q   <= IdxW'(NumReq - 1);
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      fifo_q  <= fifo_d;
    end
  end

  // Outputs. While reset is asserted they are all forced to zero so live inputs cannot leak through.
  always_comb begin
    gnt_o       = '0;
    rvalid_o    = '0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_strb_o  = '0;
    busy_o      = 1'b0;
    if (rst_ni) begin
      mem_req_o = req_int;
      if (req_int) begin
        mem_addr_o  = addr_i[sel*AddrWidth +: AddrWidth];
        mem_we_o    = we_i[sel];
        mem_wdata_o = wdata_i[sel*DataWidth +: DataWidth];
        mem_strb_o  = strb_i[sel*StrbW +: StrbW];
      end
      if (fire) begin
        gnt_o[sel] = 1'b1;
      end
      if (pop) begin
        rvalid_o[head] = 1'b1;
      end
      if (mem_rvalid_i) begin
        rdata_o = mem_rdata_i;
      end
      busy_o = (|req_i) || !empty || (state_q == ST_LOCKED);
    end
  end

`ifndef SYNTHESIS
  logic                   hold_q;
  logic [AddrWidth-1:0]   addr_prev_q;
  logic                   we_prev_q;
  logic [DataWidth-1:0]   wdata_prev_q;
  logic [StrbW-1:0]       strb_prev_q;

  // Remember the payload of a request that was issued but not granted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q       <= 1'b0;
      addr_prev_q  <= '0;
      we_prev_q    <= 1'b0;
      wdata_prev_q <= '0;
      strb_prev_q  <= '0;
    end else begin
      hold_q       <= req_int && !mem_gnt_i;
      addr_prev_q  <= mem_addr_o;
      we_prev_q    <= mem_we_o;
      wdata_prev_q <= mem_wdata_o;
      strb_prev_q  <= mem_strb_o;
    end
  end

  // Protocol checks
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert ($onehot0(gnt_o)) else $error("gnt_o not one-hot-or-zero: %b", gnt_o);
      assert ($onehot0(rvalid_o)) else $error("rvalid_o not one-hot-or-zero: %b", rvalid_o);
      assert (cnt_q <= CntW'(MaxOutstanding)) else $error("outstanding count overflow: %0d", cnt_q);
      if (hold_q) begin
        assert ((state_q == ST_LOCKED) && (mem_addr_o == addr_prev_q) && (mem_we_o == we_prev_q) &&
                (mem_wdata_o == wdata_prev_q) && (mem_strb_o == strb_prev_q))
          else $error("payload changed while locked");
      end
      if (mem_rvalid_i && empty) begin
        $warning("mem_stream_rr_arbiter: protocol error, response with no outstanding request dropped");
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_stream_rr_arbiter.sv
// Bench for mem_stream_rr_arbiter: a table of reference cycles, hand-written corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_mem_stream_rr_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MO = 2;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              busy;
  logic [NR-1:0]     req, gnt, we, rvalid;
  logic [NR*AW-1:0]  addr;
  logic [NR*DW-1:0]  wdata;
  logic [NR*SW-1:0]  strb;
  logic [DW-1:0]     rdata;
  logic              mem_req, mgnt, mem_we, mrv;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata, mrdata;
  logic [SW-1:0]     mem_strb;

  logic [AW-1:0] p_addr  [NR];
  logic          p_we    [NR];
  logic [DW-1:0] p_wdata [NR];
  logic [SW-1:0] p_strb  [NR];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      addr[i*AW +: AW]  = p_addr[i];
      we[i]             = p_we[i];
      wdata[i*DW +: DW] = p_wdata[i];
      strb[i*SW +: SW]  = p_strb[i];
    end
  end

  mem_stream_rr_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .busy_o(busy),
    .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .wdata_i(wdata), .strb_i(strb),
    .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_gnt_i(mgnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb),
    .mem_rvalid_i(mrv), .mem_rdata_i(mrdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: outstanding responses as a queue of requester numbers
  int mq[$];
  bit m_lock;
  int m_lidx;
  int m_ptr;

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    mgnt   = 1'b0;
    mrv    = 1'b0;
    mrdata = '0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mq.delete();
    m_lock = 1'b0;
    m_lidx = 0;
    m_ptr  = NR - 1;
  endtask

  task automatic drive(input logic [NR-1:0] r, input logic g, input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    req = r; mgnt = g; mrv = v; mrdata = d;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    64'(gnt), 64'h0);
    chk({tag, "_rvalid"}, 64'(rvalid), 64'h0);
    chk({tag, "_rdata"},  rdata, 64'h0);
    chk({tag, "_memreq"}, 64'(mem_req), 64'h0);
    chk({tag, "_addr"},   64'(mem_addr), 64'h0);
    chk({tag, "_we"},     64'(mem_we), 64'h0);
    chk({tag, "_wdata"},  mem_wdata, 64'h0);
    chk({tag, "_strb"},   64'(mem_strb), 64'h0);
    chk({tag, "_busy"},   64'(busy), 64'h0);
  endtask

  // Compare the DUT against the model for the current inputs, then advance the model one cycle
  task automatic model_step(output logic [NR-1:0] granted);
    bit full, mreq, fire;
    int sel;
    logic [NR-1:0] eg, erv;
    full = (mq.size() >= MO);
    sel  = -1;
    if (m_lock) sel = m_lidx;
    else begin
      for (int k = 1; k <= NR; k++) begin
        if (sel < 0 && req[(m_ptr + k) % NR]) sel = (m_ptr + k) % NR;
      end
    end
    mreq = (sel >= 0) && !full;
    fire = mreq && mgnt;
    eg = '0;
    if (fire) eg[sel] = 1'b1;
    erv = '0;
    if (mrv && mq.size() > 0) erv[mq[0]] = 1'b1;
    chk("rnd_memreq", 64'(mem_req), 64'(mreq));
    chk("rnd_gnt",    64'(gnt), 64'(eg));
    chk("rnd_rvalid", 64'(rvalid), 64'(erv));
    chk("rnd_rdata",  rdata, mrv ? mrdata : 64'h0);
    chk("rnd_busy",   64'(busy), 64'((|req) || mq.size() > 0 || m_lock));
    if (mreq) begin
      chk("rnd_addr",  64'(mem_addr), 64'(p_addr[sel]));
      chk("rnd_we",    64'(mem_we), 64'(p_we[sel]));
      chk("rnd_wdata", mem_wdata, p_wdata[sel]);
      chk("rnd_strb",  64'(mem_strb), 64'(p_strb[sel]));
    end else begin
      chk("rnd_addr_idle", 64'(mem_addr), 64'h0);
    end
    if (erv != '0) void'(mq.pop_front());
    if (fire) begin
      mq.push_back(sel);
      m_ptr  = sel;
      m_lock = 1'b0;
    end else if (mreq && !m_lock) begin
      m_lock = 1'b1;
      m_lidx = sel;
    end
    granted = eg;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic        mg;
    logic        mrv;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic        e_mreq;
    logic [31:0] e_addr;
    logic        e_busy;
  } vec_t;

  localparam int NVEC = 13;
  vec_t tbl [NVEC];

  task automatic setv(input int i, input logic [1:0] r, input logic g, input logic v,
                      input logic [1:0] eg, input logic [1:0] erv, input logic emr,
                      input logic [31:0] ea, input logic eb);
    tbl[i].req = r; tbl[i].mg = g; tbl[i].mrv = v;
    tbl[i].e_gnt = eg; tbl[i].e_rv = erv; tbl[i].e_mreq = emr;
    tbl[i].e_addr = ea; tbl[i].e_busy = eb;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NR-1:0] pend, g;

    for (int i = 0; i < NR; i++) begin
      p_addr[i] = AW'(32'h100 * (i + 1));
      p_we[i] = 1'b0;
      p_wdata[i] = 64'h1111_0000 + 64'(i);
      p_strb[i] = 8'h0F;
    end

    // Back-to-back round robin with one-cycle responses, then fill and drain of the outstanding FIFO
    //      row req    mg    mrv   e_gnt  e_rv   mreq  addr       busy
    setv(0,  2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 32'h100, 1'b1);
    setv(1,  2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 32'h200, 1'b1);
    setv(2,  2'b11, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 32'h100, 1'b1);
    setv(3,  2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 32'h200, 1'b1);
    setv(4,  2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 32'h000, 1'b1);
    setv(5,  2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 32'h100, 1'b1);
    setv(6,  2'b11, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 32'h200, 1'b1);
    setv(7,  2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h000, 1'b1);
    setv(8,  2'b11, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 32'h000, 1'b1);
    setv(9,  2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 32'h100, 1'b1);
    setv(10, 2'b11, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 32'h000, 1'b1);
    setv(11, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 32'h000, 1'b1);
    setv(12, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 32'h000, 1'b0);

    // Reset: outputs stay zero even with live inputs
    rst_n = 1'b0; req = 2'b11; mgnt = 1'b1; mrv = 1'b1; mrdata = 64'hFFFF;
    #3;
    chk_all_zero("reset");
    do_reset();
    #1;
    chk_all_zero("post_reset");

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].req, tbl[i].mg, tbl[i].mrv, 64'hA000 + 64'(i));
      chk($sformatf("tbl%0d_gnt", i),    64'(gnt), 64'(tbl[i].e_gnt));
      chk($sformatf("tbl%0d_rvalid", i), 64'(rvalid), 64'(tbl[i].e_rv));
      chk($sformatf("tbl%0d_memreq", i), 64'(mem_req), 64'(tbl[i].e_mreq));
      chk($sformatf("tbl%0d_addr", i),   64'(mem_addr), 64'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_busy", i),   64'(busy), 64'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_rdata", i),  rdata, tbl[i].mrv ? 64'hA000 + 64'(i) : 64'h0);
    end

    // A locked request holds its payload while the memory stalls
    do_reset();
    drive(2'b01, 1'b0, 1'b0, '0);
    chk("lock_c0_addr", 64'(mem_addr), 64'h100);
    chk("lock_c0_gnt", 64'(gnt), 64'h0);
    chk("lock_c0_memreq", 64'(mem_req), 64'h1);
    drive(2'b11, 1'b0, 1'b0, '0);
    chk("lock_c1_addr", 64'(mem_addr), 64'h100);
    chk("lock_c1_gnt", 64'(gnt), 64'h0);
    drive(2'b11, 1'b0, 1'b0, '0);
    chk("lock_c2_addr", 64'(mem_addr), 64'h100);
    drive(2'b11, 1'b1, 1'b0, '0);
    chk("lock_c3_gnt", 64'(gnt), 64'h1);
    chk("lock_c3_addr", 64'(mem_addr), 64'h100);
    drive(2'b10, 1'b1, 1'b0, '0);
    chk("lock_c4_gnt", 64'(gnt), 64'h2);
    chk("lock_c4_addr", 64'(mem_addr), 64'h200);

    // Write from requester 1 routed to the memory, its response routed back
    do_reset();
    p_we[1] = 1'b1; p_strb[1] = 8'hFF; p_wdata[1] = 64'hDEAD;
    drive(2'b10, 1'b1, 1'b0, '0);
    chk("wr_gnt", 64'(gnt), 64'h2);
    chk("wr_we", 64'(mem_we), 64'h1);
    chk("wr_wdata", mem_wdata, 64'hDEAD);
    chk("wr_strb", 64'(mem_strb), 64'hFF);
    chk("wr_addr", 64'(mem_addr), 64'h200);
    drive(2'b00, 1'b0, 1'b1, 64'h55);
    chk("wr_rvalid", 64'(rvalid), 64'h2);
    chk("wr_rdata", rdata, 64'h55);
    p_we[1] = 1'b0; p_strb[1] = 8'h0F; p_wdata[1] = 64'h1111_0001;

    // Spurious response with nothing outstanding is dropped and the count stays at zero
    drive(2'b00, 1'b0, 1'b1, 64'h77);
    chk("spur_rvalid", 64'(rvalid), 64'h0);
    chk("spur_busy", 64'(busy), 64'h0);
    drive(2'b00, 1'b0, 1'b0, '0);
    chk("spur_busy_after", 64'(busy), 64'h0);
    drive(2'b01, 1'b1, 1'b0, '0);
    chk("spur_next_gnt", 64'(gnt), 64'h1);
    drive(2'b00, 1'b0, 1'b1, 64'h99);
    chk("spur_next_rvalid", 64'(rvalid), 64'h1);
    drive(2'b00, 1'b0, 1'b0, '0);
    chk("spur_drained_busy", 64'(busy), 64'h0);

    // Asynchronous reset while a response is outstanding and a request is locked
    do_reset();
    drive(2'b11, 1'b1, 1'b0, '0);
    chk("mid_gnt0", 64'(gnt), 64'h1);
    drive(2'b11, 1'b0, 1'b0, '0);
    chk("mid_lock_addr", 64'(mem_addr), 64'h200);
    @(negedge clk);
    req = 2'b11; mgnt = 1'b1; mrv = 1'b1; mrdata = 64'hBEEF;
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1; req = 2'b11; mgnt = 1'b1; mrv = 1'b0; mrdata = '0;
    #1;
    chk("mid_after_gnt", 64'(gnt), 64'h1);

    // Random traffic against the reference model
    do_reset();
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
        if (!pend[r] && ($urandom % 3 == 0)) begin
          pend[r]    = 1'b1;
          p_addr[r]  = AW'($urandom);
          p_we[r]    = 1'($urandom);
          p_wdata[r] = {$urandom, $urandom};
          p_strb[r]  = SW'($urandom);
        end
      end
      req    = pend;
      mgnt   = ($urandom % 4) != 0;
      mrv    = (mq.size() > 0) && (($urandom % 3) != 0);
      mrdata = {$urandom, $urandom};
      #1;
      model_step(g);
      pend = pend & ~g;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
